// File: rtl/weighted_sum_sched.sv
// weighted_sum_sched
//   Arbitrates two requesters (group A: n0..n2, group B: n3..n5) onto one
//   shift-add datapath computing K0*x0 + K1*x1 + K2*x2. Each computation
//   spends one cycle per weighted term and then holds the result on a
//   valid/ready output until it is consumed.
//
// Ports
//   clk, rst_n          : clock, synchronous active-low reset
//   mode[1:0]           : 00/11 round-robin, 01 fixed priority A, 10 fixed priority B
//   req_a, n0..n2       : group A request (level) and operands
//   ack_a               : group A operands captured this cycle
//   req_b, n3..n5       : group B request (level) and operands
//   ack_b               : group B operands captured this cycle
//   out_valid/out_ready : result handshake
//   out_n, out_id       : weighted sum and its source (0 = A, 1 = B)
//   busy                : high whenever the sequencer is not idle
module weighted_sum_sched #(
    parameter int unsigned W_IN  = 6,
    parameter int unsigned W_OUT = 10,
    parameter int unsigned K0    = 3,
    parameter int unsigned K1    = 4,
    parameter int unsigned K2    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             req_a,
    input  logic [W_IN-1:0]  n0,
    input  logic [W_IN-1:0]  n1,
    input  logic [W_IN-1:0]  n2,
    output logic             ack_a,
    input  logic             req_b,
    input  logic [W_IN-1:0]  n3,
    input  logic [W_IN-1:0]  n4,
    input  logic [W_IN-1:0]  n5,
    output logic             ack_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_OUT-1:0] out_n,
    output logic             out_id,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC0,
        S_ACC1,
        S_ACC2,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic              r_last;     // most recent grant: 0 = A, 1 = B
    logic [W_IN-1:0]   r_op0;
    logic [W_IN-1:0]   r_op1;
    logic [W_IN-1:0]   r_op2;
    logic [W_OUT-1:0]  r_acc;
    logic [W_OUT-1:0]  r_out_n;
    logic              r_out_id;

    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_ack_a;
    logic              w_ack_b;
    logic [W_OUT-1:0]  w_term;

    // Constant multiply unrolled into shifted adds of the operand, one per
    // set bit of the weight; the result wraps modulo 2^W_OUT.
    function automatic logic [W_OUT-1:0] mul_const(input logic [W_OUT-1:0] op,
                                                   input int unsigned     k);
        logic [W_OUT-1:0] sum;
        sum = '0;
        for (int unsigned i = 0; i < W_OUT && i < 32; i++) begin
            if (((k >> i) & 32'd1) != 32'd0)
                sum = sum + (op << i);
        end
        return sum;
    endfunction

    // Arbitration: a lone request always wins; a tie is resolved by mode.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (req_a && req_b) begin
            unique case (mode)
                2'b01:   w_grant_a = 1'b1;
                2'b10:   w_grant_b = 1'b1;
                default: begin
                    w_grant_a = r_last;
                    w_grant_b = ~r_last;
                end
            endcase
        end else begin
            w_grant_a = req_a;
            w_grant_b = req_b;
        end
    end

    assign w_ack_a = (r_state == S_IDLE) & w_grant_a & rst_n;
    assign w_ack_b = (r_state == S_IDLE) & w_grant_b & rst_n;

    // Weighted term contributed in the current accumulate cycle.
    always_comb begin
        w_term = '0;
        unique case (r_state)
            S_ACC0:  w_term = mul_const(W_OUT'(r_op0), K0);
            S_ACC1:  w_term = mul_const(W_OUT'(r_op1), K1);
            S_ACC2:  w_term = mul_const(W_OUT'(r_op2), K2);
            default: w_term = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:  if (w_ack_a || w_ack_b) w_next_state = S_ACC0;
            S_ACC0:  w_next_state = S_ACC1;
            S_ACC1:  w_next_state = S_ACC2;
            S_ACC2:  w_next_state = S_DONE;
            S_DONE:  if (out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last   <= 1'b1;
            r_op0    <= '0;
            r_op1    <= '0;
            r_op2    <= '0;
            r_acc    <= '0;
            r_out_n  <= '0;
            r_out_id <= 1'b0;
        end else if (w_ack_a || w_ack_b) begin
            r_op0    <= w_ack_b ? n3 : n0;
            r_op1    <= w_ack_b ? n4 : n1;
            r_op2    <= w_ack_b ? n5 : n2;
            r_out_id <= w_ack_b;
            r_last   <= w_ack_b;
            r_acc    <= '0;
        end else if (r_state == S_ACC0 || r_state == S_ACC1) begin
            r_acc    <= r_acc + w_term;
        end else if (r_state == S_ACC2) begin
            // Final term goes straight into the output register.
            r_out_n  <= r_acc + w_term;
        end
    end

    assign ack_a     = w_ack_a;
    assign ack_b     = w_ack_b;
    assign out_valid = (r_state == S_DONE);
    assign out_n     = r_out_n;
    assign out_id    = r_out_id;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_weighted_sum_sched.sv
// tb_weighted_sum_sched
//   Directed scenarios followed by randomized traffic, all checked against a
//   transaction-level reference (cycles since acceptance, sum computed with
//   plain multiplication).
module tb_weighted_sum_sched;

    localparam int unsigned W_IN  = 6;
    localparam int unsigned W_OUT = 10;
    localparam int unsigned K0    = 3;
    localparam int unsigned K1    = 4;
    localparam int unsigned K2    = 5;

    logic             clk;
    logic             rst_n;
    logic [1:0]       mode;
    logic             req_a;
    logic [W_IN-1:0]  n0, n1, n2;
    logic             ack_a;
    logic             req_b;
    logic [W_IN-1:0]  n3, n4, n5;
    logic             ack_b;
    logic             out_valid;
    logic             out_ready;
    logic [W_OUT-1:0] out_n;
    logic             out_id;
    logic             busy;

    weighted_sum_sched #(
        .W_IN (W_IN),
        .W_OUT(W_OUT),
        .K0   (K0),
        .K1   (K1),
        .K2   (K2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .req_a    (req_a),
        .n0       (n0),
        .n1       (n1),
        .n2       (n2),
        .ack_a    (ack_a),
        .req_b    (req_b),
        .n3       (n3),
        .n4       (n4),
        .n5       (n5),
        .ack_b    (ack_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_n    (out_n),
        .out_id   (out_id),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: m_cnt = cycles since acceptance (0 = idle, 4 = result held).
    int unsigned m_cnt  = 0;
    logic        m_last = 1'b1;
    int unsigned m_out_n = 0;
    logic        m_id   = 1'b0;
    int unsigned m_pend = 0;

    // Values sampled from the DUT in the most recent cycle.
    logic             s_ack_a, s_ack_b, s_valid, s_busy, s_id, s_ready;
    logic [W_OUT-1:0] s_out_n;

    task automatic cycle();
        logic ga, gb, e_ack_a, e_ack_b;
        @(negedge clk);
        ga = 1'b0;
        gb = 1'b0;
        if (req_a && req_b) begin
            if (mode == 2'b01)      ga = 1'b1;
            else if (mode == 2'b10) gb = 1'b1;
            else if (m_last)        ga = 1'b1;
            else                    gb = 1'b1;
        end else begin
            ga = req_a;
            gb = req_b;
        end
        e_ack_a = rst_n && (m_cnt == 0) && ga;
        e_ack_b = rst_n && (m_cnt == 0) && gb;

        s_ack_a = ack_a;
        s_ack_b = ack_b;
        s_valid = out_valid;
        s_busy  = busy;
        s_out_n = out_n;
        s_id    = out_id;
        s_ready = out_ready;

        check("ack_a",     32'(s_ack_a), 32'(e_ack_a));
        check("ack_b",     32'(s_ack_b), 32'(e_ack_b));
        check("out_valid", 32'(s_valid), 32'(m_cnt == 4));
        check("busy",      32'(s_busy),  32'(m_cnt != 0));
        check("out_n",     32'(s_out_n), m_out_n);
        check("out_id",    32'(s_id),    32'(m_id));

        @(posedge clk);
        if (!rst_n) begin
            m_cnt   = 0;
            m_last  = 1'b1;
            m_out_n = 0;
            m_id    = 1'b0;
        end else if (e_ack_a || e_ack_b) begin
            m_cnt  = 1;
            m_id   = e_ack_b;
            m_last = e_ack_b;
            if (e_ack_b) m_pend = (K0*n3 + K1*n4 + K2*n5) % (1 << W_OUT);
            else         m_pend = (K0*n0 + K1*n1 + K2*n2) % (1 << W_OUT);
        end else if (m_cnt >= 1 && m_cnt <= 3) begin
            m_cnt++;
            if (m_cnt == 4) m_out_n = m_pend;
        end else if (m_cnt == 4 && s_ready) begin
            m_cnt = 0;
        end
        #1;
    endtask

    task automatic drain();
        req_a     = 1'b0;
        req_b     = 1'b0;
        out_ready = 1'b1;
        repeat (6) cycle();
    endtask

    initial begin
        int  exp_id;
        int  nres;
        bit  seen;
        logic [W_OUT-1:0] held_n;
        logic             held_id;

        rst_n = 1'b0; mode = 2'b00; req_a = 1'b0; req_b = 1'b0; out_ready = 1'b1;
        n0 = '0; n1 = '0; n2 = '0; n3 = '0; n4 = '0; n5 = '0;
        repeat (2) cycle();
        check("rst_out_n", 32'(s_out_n), 0);
        check("rst_valid", 32'(s_valid), 0);
        rst_n = 1'b1;

        // Single A request: 3*1 + 4*2 + 5*3 = 26, valid 4 cycles after ack.
        req_a = 1'b1; n0 = 6'd1; n1 = 6'd2; n2 = 6'd3;
        cycle();
        check("t1_ack", 32'(s_ack_a), 1);
        req_a = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cycle();
            check("t1_busy", 32'(s_busy), 1);
            check("t1_valid", 32'(s_valid), 32'(i == 4));
        end
        check("t1_sum", 32'(s_out_n), 26);
        check("t1_id", 32'(s_id), 0);
        cycle();
        check("t1_idle", 32'(s_busy), 0);

        // Maximum operands on B: 12 * 63 = 756.
        req_b = 1'b1; n3 = 6'd63; n4 = 6'd63; n5 = 6'd63;
        cycle();
        check("t2_ack", 32'(s_ack_b), 1);
        req_b = 1'b0;
        repeat (4) cycle();
        check("t2_valid", 32'(s_valid), 1);
        check("t2_sum", 32'(s_out_n), 756);
        check("t2_id", 32'(s_id), 1);

        // Round-robin alternation from reset, A first.
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        mode = 2'b00; req_a = 1'b1; req_b = 1'b1;
        n0 = 6'd0; n1 = 6'd0; n2 = 6'd1; n3 = 6'd1; n4 = 6'd0; n5 = 6'd0;
        exp_id = 0; nres = 0;
        for (int i = 0; i < 24; i++) begin
            cycle();
            if (s_valid && s_ready) begin
                check("rr_id", 32'(s_id), 32'(exp_id));
                check("rr_sum", 32'(s_out_n), exp_id ? 3 : 5);
                exp_id ^= 1;
                nres++;
            end
        end
        check("rr_count", 32'(nres >= 4), 1);

        // Fixed priority B, then fixed priority A.
        drain();
        mode = 2'b10; req_a = 1'b1; req_b = 1'b1; nres = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            check("fpb_no_ack_a", 32'(s_ack_a), 0);
            if (s_valid) begin check("fpb_id", 32'(s_id), 1); nres++; end
        end
        check("fpb_count", 32'(nres > 0), 1);
        drain();
        mode = 2'b01; req_a = 1'b1; req_b = 1'b1; nres = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            check("fpa_no_ack_b", 32'(s_ack_b), 0);
            if (s_valid) begin check("fpa_id", 32'(s_id), 0); nres++; end
        end
        check("fpa_count", 32'(nres > 0), 1);

        // Backpressure: result 3*10 + 4*20 + 5*30 = 260 held while not ready.
        drain();
        mode = 2'b00; out_ready = 1'b0; req_a = 1'b1;
        n0 = 6'd10; n1 = 6'd20; n2 = 6'd30;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle();
            req_a = 1'b0;
            seen = s_valid;
        end
        check("bp_valid_seen", 32'(seen), 1);
        check("bp_sum", 32'(s_out_n), 260);
        held_n = s_out_n; held_id = s_id;
        req_a = 1'b1; req_b = 1'b1;
        repeat (6) begin
            cycle();
            check("bp_hold_n", 32'(s_out_n), 32'(held_n));
            check("bp_hold_id", 32'(s_id), 32'(held_id));
            check("bp_no_ack", 32'(s_ack_a | s_ack_b), 0);
        end
        out_ready = 1'b1;
        cycle();
        check("bp_handshake", 32'(s_valid), 1);
        cycle();
        check("bp_next_ack", 32'(s_ack_a | s_ack_b), 1);

        // Reset during ACC1 aborts the computation; tie then goes to A.
        drain();
        mode = 2'b00; req_a = 1'b1; req_b = 1'b1;
        n0 = 6'd7; n1 = 6'd7; n2 = 6'd7; n3 = 6'd9; n4 = 6'd9; n5 = 6'd9;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle();
            seen = s_ack_a | s_ack_b;
        end
        check("rst_mid_ack_seen", 32'(seen), 1);
        cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        check("rst_mid_busy", 32'(s_busy), 0);
        check("rst_mid_valid", 32'(s_valid), 0);
        check("rst_mid_out_n", 32'(s_out_n), 0);
        check("rst_mid_tie_a", 32'(s_ack_a), 1);

        // Randomized traffic with occasional resets and operand churn.
        for (int i = 0; i < 1500; i++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            mode      = 2'($urandom_range(0, 3));
            req_a     = 1'($urandom_range(0, 1));
            req_b     = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            n0 = 6'($urandom_range(0, 63)); n1 = 6'($urandom_range(0, 63));
            n2 = 6'($urandom_range(0, 63)); n3 = 6'($urandom_range(0, 63));
            n4 = 6'($urandom_range(0, 63)); n5 = 6'($urandom_range(0, 63));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/weighted_sum_sched.md
# weighted_sum_sched

Sequencer and arbiter for a shared weighted-sum datapath computing K0·x0 + K1·x1 + K2·x2. Two requesters compete for the single unit:

- **Group A** supplies operands N0..N2 (the "larger" set).
- **Group B** supplies operands N3..N5 (the "smaller" set).

The block arbitrates per `mode`, captures the winner's operands, and accumulates one weighted term per cycle over three cycles. It presents the result on a valid/ready output port, so one adder serves both groups.

## Interface

Parameters:
- `W_IN`, default 6: operand width.
- `W_OUT`, default 10: result width. Must hold (K0+K1+K2)·(2^W_IN−1); the default maximum is 756.
- `K0`, default 3: weight on first operand.
- `K1`, default 4: weight on second operand.
- `K2`, default 5: weight on third operand.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `mode` in 2: arbitration policy. 00/11 = round-robin, 01 = fixed priority A, 10 = fixed priority B.
- `req_a` in 1: group A request (level).
- `n0`, `n1`, `n2` in W_IN each: group A operands, weights K0, K1, K2 respectively.
- `ack_a` out 1: group A operands captured this cycle.
- `req_b` in 1: group B request (level).
- `n3`, `n4`, `n5` in W_IN each: group B operands, weights K0, K1, K2 respectively.
- `ack_b` out 1: group B operands captured this cycle.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_n` out W_OUT: weighted sum.
- `out_id` out 1: source of the result, 0 = A, 1 = B.
- `busy` out 1: high whenever the state is not IDLE.

## Operation

- **States:** IDLE, ACC0, ACC1, ACC2, DONE.
- **IDLE:**
  - Compute grant from `req_a`, `req_b`, `mode` and `last` (the most recently granted source).
  - Round-robin: on a tie, grant the source that is not `last`.
  - Fixed priority: on a tie, the preferred source always wins.
  - A lone request is always granted.
- **Acknowledge:**
  - `ack_x` is combinational and equals (state==IDLE) & grant_x & `rst_n`.
  - At most one ack is high in any cycle.
- **Capture:** on an acknowledge edge:
  - latch the three operands of the winner,
  - set `out_id`,
  - update `last`,
  - clear the accumulator,
  - go to ACC0.
- **ACC0 / ACC1 / ACC2:**
  - In ACCj, acc ← acc + Kj·opj.
  - Constant multiply is implemented as shift-add; no general multiplier.
  - Arithmetic is unsigned, modulo 2^W_OUT.
  - After ACC2, register `out_n` = final acc and go to DONE.
- **DONE:**
  - `out_valid` = 1; `out_n` and `out_id` are held stable.
  - On `out_valid` & `out_ready`, go to IDLE.
- **Operand handling:**
  - Requests are not accepted outside IDLE; the corresponding ack stays 0.
  - Operand changes after capture have no effect.
  - A request deasserted before its ack is simply dropped; no state is kept.
- **Mode sampling:** `mode` is sampled only in IDLE; a change mid-computation affects the next grant only.
- **Reset** (`rst_n`=0 at a clock edge), whatever the current state:
  - state = IDLE,
  - `last` = B, so A wins the first round-robin tie,
  - acc = 0, `out_n` = 0, `out_id` = 0, `out_valid` = 0,
  - acks forced to 0 while `rst_n` is low.
- **Reset mid-operation:** the computation in flight is aborted and no `out_valid` is produced for it.

## Timing

- Request accepted in cycle T (ack high in T).
- ACC0/1/2 occupy cycles T+1, T+2, T+3.
- `out_valid` = 1 from cycle T+4; latency is 4 cycles.
- Output handshake in cycle U means IDLE in U+1; the earliest next ack is in U+1.
- Peak throughput is one result per 5 cycles with `out_ready` tied high.
- `busy` is high from T+1 through U inclusive.
- Backpressure: with `out_ready` low, DONE persists indefinitely with outputs stable and no acks issued.
- Reset values:
  - `out_n` = 0, `out_id` = 0, `out_valid` = 0, `busy` = 0,
  - `ack_a` = 0, `ack_b` = 0.

## Test plan

- **Single A request:** `mode`=00, `req_a`=1, n0/n1/n2 = 1/2/3, `out_ready`=1 → `ack_a` high in cycle 0; `out_valid` in cycle 4 with `out_n`=26, `out_id`=0; `busy` high cycles 1–4.
- **Maximum operands on B:** `req_b`=1, n3 = n4 = n5 = 63 → `out_n`=756, `out_id`=1, no overflow.
- **Round-robin:** after reset, `req_a` = `req_b` = 1 continuously, `mode`=00 → results alternate A, B, A, B; A operands 0/0/1 give 5, B operands 1/0/0 give 3.
- **Fixed priority:** `mode`=10, both requesting continuously → every result has `out_id`=1 and `ack_a` never asserts. Then `mode`=01 → `out_id`=0 on every result.
- **Backpressure:**
  - `out_ready`=0 for 6 cycles after `out_valid` rises → `out_n` and `out_id` stable, `ack_a` and `ack_b` stay 0 despite requests.
  - `out_ready`=1 → handshake, then IDLE and an ack on the following cycle.
- **Reset mid-operation:**
  - `rst_n`=0 during ACC1 → next cycle IDLE, `out_valid`=0, `out_n`=0, `busy`=0, and the aborted result never appears.
  - After release, a tie goes to A.
